// File: rtl/mem_copy_pkg.sv
// Shared types for the memory copy engine: FSM state encoding and counter sizing.
package mem_copy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StFinish
  } state_e;

  // The remaining-word counter needs one extra bit so a full 2^ADDR_WIDTH copy fits.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/mem_copy_watchdog.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module mem_copy_watchdog #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_copy_engine.sv
// Single-outstanding word copier: read one word, write it, advance, repeat; aborts on read timeout.
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_aready,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready
);

  localparam int unsigned CW = cnt_width(ADDR_WIDTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [CW-1:0]         rem_q, rem_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d, w_addr_q, w_addr_d;
  logic                  r_avalid_q, r_avalid_d, w_valid_q, w_valid_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  wd_clear, wd_load, wd_dec, wd_expired;

  // Loaded with TIMEOUT-1 so RD_WAIT lasts at most TIMEOUT cycles.
  mem_copy_watchdog #(
    .WIDTH (TW)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .load     (wd_load),
    .load_val (TW'(TIMEOUT - 1)),
    .dec      (wd_dec),
    .expired  (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    r_addr_d   = r_addr_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    r_avalid_d = 1'b0;
    w_valid_d  = 1'b0;
    done_d     = 1'b0;
    error_d    = 1'b0;
    wd_clear   = 1'b0;
    wd_load    = 1'b0;
    wd_dec     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            src_d      = src_addr;
            dst_d      = dst_addr;
            rem_d      = len;
            r_addr_d   = src_addr;
            r_avalid_d = 1'b1;
            state_d    = StRdReq;
          end else begin
            done_d  = 1'b1;
            state_d = StFinish;
          end
        end
      end
      StRdReq: begin
        r_avalid_d = 1'b1;
        if (r_aready) begin
          r_avalid_d = 1'b0;
          wd_load    = 1'b1;
          state_d    = StRdWait;
        end
      end
      StRdWait: begin
        if (r_dvalid) begin
          w_data_d  = r_data;
          w_addr_d  = dst_q;
          w_valid_d = 1'b1;
          wd_clear  = 1'b1;
          state_d   = StWrReq;
        end else if (wd_expired) begin
          done_d   = 1'b1;
          error_d  = 1'b1;
          wd_clear = 1'b1;
          state_d  = StFinish;
        end else begin
          wd_dec = 1'b1;
        end
      end
      StWrReq: begin
        w_valid_d = 1'b1;
        if (w_ready) begin
          w_valid_d = 1'b0;
          src_d     = src_q + ADDR_WIDTH'(1);
          dst_d     = dst_q + ADDR_WIDTH'(1);
          rem_d     = rem_q - CW'(1);
          if (rem_q == CW'(1)) begin
            done_d  = 1'b1;
            state_d = StFinish;
          end else begin
            r_addr_d   = src_q + ADDR_WIDTH'(1);
            r_avalid_d = 1'b1;
            state_d    = StRdReq;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    busy_d = (state_d == StRdReq) || (state_d == StRdWait) || (state_d == StWrReq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      r_addr_q   <= '0;
      r_avalid_q <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      w_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      r_addr_q   <= r_addr_d;
      r_avalid_q <= r_avalid_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      w_valid_q  <= w_valid_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign r_addr   = r_addr_q;
  assign r_avalid = r_avalid_q;
  assign w_addr   = w_addr_q;
  assign w_data   = w_data_q;
  assign w_valid  = w_valid_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: a 16-word memory responder with random handshake delays and a word-copy model.
module tb_mem_copy_engine;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TO = 15;
  localparam int NW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, error;
  logic [AW-1:0] r_addr, w_addr;
  logic          r_avalid, w_valid;
  logic          r_aready = 1'b0;
  logic          r_dvalid = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic [DW-1:0] w_data;
  logic          w_ready = 1'b0;

  mem_copy_engine #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .r_addr   (r_addr),
    .r_avalid (r_avalid),
    .r_aready (r_aready),
    .r_dvalid (r_dvalid),
    .r_data   (r_data),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_valid  (w_valid),
    .w_ready  (w_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] mem  [NW];
  logic [DW-1:0] expm [NW];

  int ack_lo, ack_hi, dat_lo, dat_hi;
  bit no_data, stray;
  int rd_ph, rd_cnt, wr_ph, wr_cnt;
  logic [AW-1:0] rd_a, wa;
  logic [DW-1:0] wd;
  int done_cnt, err_cnt, stab_err, excl_err, av_cyc, wv_cyc, ack_cyc, done_cyc;
  int rd_log[$];
  int wr_log[$];
  int vectors, miscompares;

  function automatic int pick(input int lo, input int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  // One clock of the memory responder; inputs change only at the falling edge.
  task automatic tick();
    @(negedge clk);
    r_aready = 1'b0;
    r_dvalid = 1'b0;
    w_ready  = 1'b0;
    if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
    if (error === 1'b1) err_cnt++;
    if (error === 1'b1 && done !== 1'b1) excl_err++;
    if (r_avalid === 1'b1 && w_valid === 1'b1) excl_err++;
    if (r_avalid === 1'b1) av_cyc++;
    if (w_valid === 1'b1) wv_cyc++;
    if (rst || busy !== 1'b1) begin
      rd_ph = 0;
      wr_ph = 0;
    end else begin
      if (rd_ph == 0 && r_avalid) begin
        rd_a = r_addr; rd_cnt = pick(ack_lo, ack_hi); rd_ph = 1;
      end
      if (rd_ph == 1) begin
        if (!r_avalid || r_addr !== rd_a) stab_err++;
        if (rd_cnt == 0) begin
          r_aready = 1'b1; rd_log.push_back(int'(rd_a)); ack_cyc = cyc;
          rd_cnt = pick(dat_lo, dat_hi); rd_ph = 2;
        end else begin
          rd_cnt--;
          if (stray) begin r_dvalid = 1'b1; r_data = $urandom; w_ready = 1'b1; end
        end
      end else if (rd_ph == 2) begin
        if (rd_cnt == 0 && !no_data) begin
          r_dvalid = 1'b1; r_data = mem[rd_a]; rd_ph = 0;
        end else begin
          if (rd_cnt != 0) rd_cnt--;
          if (stray) begin r_aready = 1'b1; w_ready = 1'b1; end
        end
      end
      if (wr_ph == 0 && w_valid) begin
        wa = w_addr; wd = w_data; wr_cnt = pick(ack_lo, ack_hi); wr_ph = 1;
      end
      if (wr_ph == 1) begin
        if (!w_valid || w_addr !== wa || w_data !== wd) stab_err++;
        if (wr_cnt == 0) begin
          w_ready = 1'b1; mem[wa] = wd; wr_log.push_back(int'(wa)); wr_ph = 0;
        end else begin
          wr_cnt--;
          if (stray) r_aready = 1'b1;
        end
      end
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic knobs(input int al, input int ah, input int dl, input int dh, input bit st);
    ack_lo = al; ack_hi = ah; dat_lo = dl; dat_hi = dh; stray = st; no_data = 1'b0;
  endtask

  task automatic launch(input int s, input int d, input int n);
    src_addr = s[AW-1:0]; dst_addr = d[AW-1:0]; len = n[AW:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int bound, output int cycles);
    cycles = 0;
    while (done_cnt == base && cycles < bound) begin tick(); cycles++; end
    vectors++;
    if (done_cnt == base) begin
      miscompares++; $display("FAIL done_wait: done=0 after %0d cycles, required done=1", bound);
    end
  endtask

  // Reference: sequential word-by-word copy, addresses modulo the memory size.
  task automatic build_exp(input int s, input int d, input int n);
    for (int i = 0; i < NW; i++) expm[i] = mem[i];
    for (int i = 0; i < n; i++) expm[(d + i) % NW] = expm[(s + i) % NW];
  endtask

  function automatic int mem_bad();
    int b = 0;
    for (int i = 0; i < NW; i++) if (mem[i] !== expm[i]) b++;
    return b;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    settle(2);
    vectors++;
    if ({busy, done, error, r_avalid, w_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 00000", {busy, done, error, r_avalid, w_valid});
    end
    vectors++;
    if ({r_addr, w_addr} !== '0) begin
      miscompares++; $display("FAIL reset_addr: got %0h/%0h required 0/0", r_addr, w_addr);
    end
    vectors++;
    if (w_data !== '0) begin
      miscompares++; $display("FAIL reset_wdata: got %0h required 0", w_data);
    end
    rst = 1'b0;
    settle(2);
  endtask

  task automatic test_basic();
    int d0, e0, w0, c;
    knobs(0, 0, 2, 2, 1'b0);
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;
    build_exp(0, 8, 4);
    d0 = done_cnt; e0 = err_cnt; w0 = wr_log.size();
    launch(0, 8, 4);
    wait_done(d0, 200, c);
    settle(3);
    vectors++;
    if (mem_bad() != 0) begin
      miscompares++; $display("FAIL basic_mem: %0d words wrong, required 0", mem_bad());
    end
    vectors++;
    if (mem[11] !== 32'hA3) begin
      miscompares++; $display("FAIL basic_last: mem[11]=%0h required a3", mem[11]);
    end
    vectors++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      miscompares++;
      $display("FAIL basic_done: done=%0d err=%0d required 1/0", done_cnt - d0, err_cnt - e0);
    end
    vectors++;
    if (wr_log.size() - w0 != 4) begin
      miscompares++; $display("FAIL basic_writes: got %0d required 4", wr_log.size() - w0);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL basic_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_wrap();
    int r0, w0, d0, c, bad;
    knobs(0, 3, 0, 3, 1'b0);
    build_exp(14, 2, 3);
    r0 = rd_log.size(); w0 = wr_log.size(); d0 = done_cnt;
    launch(14, 2, 3);
    wait_done(d0, 200, c);
    settle(2);
    bad = 0;
    if (rd_log.size() - r0 != 3 || wr_log.size() - w0 != 3) bad = 99;
    else for (int i = 0; i < 3; i++) begin
      if (rd_log[r0 + i] != (14 + i) % NW) bad++;
      if (wr_log[w0 + i] != 2 + i) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL wrap_addr: %0d address errors, required 0", bad);
    end
    vectors++;
    if (mem_bad() != 0) begin
      miscompares++; $display("FAIL wrap_mem: %0d words wrong, required 0", mem_bad());
    end
  endtask

  task automatic test_len_zero();
    int d0, a0, v0, c;
    knobs(0, 0, 0, 0, 1'b0);
    d0 = done_cnt; a0 = av_cyc; v0 = wv_cyc;
    launch(3, 7, 0);
    wait_done(d0, 5, c);
    settle(3);
    vectors++;
    if (c > 1) begin
      miscompares++; $display("FAIL len0_latency: %0d extra cycles, required <=1", c);
    end
    vectors++;
    if (av_cyc != a0 || wv_cyc != v0) begin
      miscompares++;
      $display("FAIL len0_quiet: avalid %0d wvalid %0d cycles, required 0/0", av_cyc - a0, wv_cyc - v0);
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL len0_done: got %0d pulses required 1", done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int d0, e0, v0, x0, c;
    knobs(0, 2, 0, 0, 1'b0);
    no_data = 1'b1;
    build_exp(5, 9, 0);
    d0 = done_cnt; e0 = err_cnt; v0 = wv_cyc; x0 = excl_err;
    launch(5, 9, 2);
    wait_done(d0, 100, c);
    vectors++;
    if (done_cyc - ack_cyc != TO + 1) begin
      miscompares++;
      $display("FAIL timeout_cycles: done %0d cycles after aready, required %0d", done_cyc - ack_cyc, TO + 1);
    end
    settle(3);
    no_data = 1'b0;
    vectors++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 1 || excl_err != x0) begin
      miscompares++;
      $display("FAIL timeout_flags: err=%0d done=%0d split=%0d required 1/1/0", err_cnt - e0, done_cnt - d0, excl_err - x0);
    end
    vectors++;
    if (wv_cyc != v0 || mem_bad() != 0) begin
      miscompares++; $display("FAIL timeout_nowrite: wvalid cycles %0d, required 0", wv_cyc - v0);
    end
  endtask

  task automatic test_latency_edge();
    int d0, e0, c;
    knobs(0, 2, TO - 1, TO - 1, 1'b0);
    build_exp(4, 12, 2);
    d0 = done_cnt; e0 = err_cnt;
    launch(4, 12, 2);
    wait_done(d0, 200, c);
    settle(2);
    vectors++;
    if (err_cnt != e0 || mem_bad() != 0) begin
      miscompares++;
      $display("FAIL late_data: err=%0d bad words=%0d required 0/0", err_cnt - e0, mem_bad());
    end
  endtask

  task automatic test_busy_start();
    int d0, w0, a1, r1, c;
    knobs(0, 3, 0, 3, 1'b0);
    build_exp(1, 10, 3);
    d0 = done_cnt; w0 = wr_log.size();
    launch(1, 10, 3);
    settle(2);
    src_addr = 4'd0; dst_addr = 4'd12; len = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, 300, c);
    // DUT is now in FINISH; this start must be dropped as well.
    a1 = av_cyc; r1 = rd_log.size();
    src_addr = 4'd0; dst_addr = 4'd1; len = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    settle(4);
    vectors++;
    if (mem_bad() != 0 || wr_log.size() - w0 != 3) begin
      miscompares++;
      $display("FAIL busy_start: writes=%0d bad=%0d required 3/0", wr_log.size() - w0, mem_bad());
    end
    vectors++;
    if (done_cnt - d0 != 1) begin
      miscompares++; $display("FAIL busy_done: got %0d pulses required 1", done_cnt - d0);
    end
    vectors++;
    if (av_cyc != a1 || rd_log.size() != r1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL finish_start: avalid cycles %0d busy %b required 0/0", av_cyc - a1, busy);
    end
  endtask

  task automatic test_reset_midcopy();
    int d0, c, a1;
    knobs(5, 5, 1, 1, 1'b0);
    build_exp(2, 6, 0);
    d0 = done_cnt;
    launch(2, 6, 2);
    c = 0;
    while (w_valid !== 1'b1 && c < 60) begin tick(); c++; end
    vectors++;
    if (w_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_reach_wr: w_valid=%b required 1", w_valid);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if ({busy, done, error, r_avalid, w_valid, r_addr, w_addr, w_data} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: busy=%b done=%b wv=%b wa=%0h wd=%0h required all 0", busy, done, w_valid, w_addr, w_data);
    end
    rst = 1'b0;
    a1 = av_cyc;
    settle(6);
    vectors++;
    if (done_cnt != d0 || mem_bad() != 0 || av_cyc != a1) begin
      miscompares++;
      $display("FAIL rst_mid_abort: done=%0d bad=%0d avalid=%0d required 0/0/0", done_cnt - d0, mem_bad(), av_cyc - a1);
    end
  endtask

  task automatic test_random();
    int s, d, n, d0, e0, w0, r0, s0, x0, c, bad;
    for (int it = 0; it < 25; it++) begin
      knobs(0, 5, 0, 5, 1'($urandom_range(1, 0)));
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      s = pick(0, NW - 1); d = pick(0, NW - 1);
      n = (it == 0) ? NW : pick(1, NW);
      build_exp(s, d, n);
      d0 = done_cnt; e0 = err_cnt; w0 = wr_log.size(); r0 = rd_log.size();
      s0 = stab_err; x0 = excl_err;
      launch(s, d, n);
      wait_done(d0, 2000, c);
      settle(2);
      bad = 0;
      if (rd_log.size() - r0 != n) bad = 99;
      else for (int i = 0; i < n; i++) if (rd_log[r0 + i] != (s + i) % NW) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++; $display("FAIL rand_reads it%0d: %0d errors required 0", it, bad);
      end
      vectors++;
      if (wr_log.size() - w0 != n || mem_bad() != 0) begin
        miscompares++;
        $display("FAIL rand_writes it%0d: writes=%0d bad=%0d required %0d/0", it, wr_log.size() - w0, mem_bad(), n);
      end
      vectors++;
      if (stab_err != s0 || excl_err != x0) begin
        miscompares++;
        $display("FAIL rand_stable it%0d: stability=%0d overlap=%0d required 0/0", it, stab_err - s0, excl_err - x0);
      end
      vectors++;
      if (done_cnt - d0 != 1 || err_cnt != e0) begin
        miscompares++;
        $display("FAIL rand_done it%0d: done=%0d err=%0d required 1/0", it, done_cnt - d0, err_cnt - e0);
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    done_cnt = 0; err_cnt = 0; stab_err = 0; excl_err = 0;
    av_cyc = 0; wv_cyc = 0; ack_cyc = 0; done_cyc = 0;
    rd_ph = 0; wr_ph = 0; rd_cnt = 0; wr_cnt = 0;
    knobs(0, 0, 0, 0, 1'b0);
    for (int i = 0; i < NW; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_timeout();
    test_latency_edge();
    test_busy_start();
    test_reset_midcopy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
